// File: rtl/spike_filter_sched_pkg.sv
// ============================================================================
// Module   : spike_filter_sched_pkg
// Desc     : Default widths and grant-pointer type for the spike filter scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

package spike_filter_sched_pkg;

  localparam int DEF_NTAG  = 11;
  localparam int DEF_NCT   = 10;
  localparam int DEF_NPER  = 24;
  localparam int DEF_NSTAT = 16;

  typedef enum logic {
    GRANT0 = 1'b0,
    GRANT1 = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/spike_filter_sched_update_timer.sv
// ============================================================================
// Module   : update_timer
// Desc     : Periodic single-cycle decay-update pulse generator
// Revision : 1.0
// ============================================================================
`default_nettype none

module update_timer
  import spike_filter_sched_pkg::*;
#(
  parameter int NPER = DEF_NPER
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [NPER-1:0] update_period,
  output logic            update_pulse
);

  localparam logic [NPER-1:0] c_one = NPER'(1);

  logic [NPER-1:0] r_cnt;
  logic            r_pulse;
  logic            w_run;
  logic            w_wrap;

  assign w_run  = enable && (update_period != '0);
  // >= rather than == so that shrinking the period below the count still fires
  assign w_wrap = (r_cnt >= (update_period - c_one));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (!w_run) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_pulse <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + c_one;
      r_pulse <= 1'b0;
    end
  end

  assign update_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/spike_filter_sched.sv
// ============================================================================
// Module   : spike_filter_sched
// Desc     : Two-input round-robin merge into one registered tag/count stream
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_filter_sched
  import spike_filter_sched_pkg::*;
#(
  parameter int NTAG  = DEF_NTAG,
  parameter int NCT   = DEF_NCT,
  parameter int NPER  = DEF_NPER,
  parameter int NSTAT = DEF_NSTAT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in0_v,
  input  logic [NTAG-1:0]  in0_tag,
  input  logic [NCT-1:0]   in0_ct,
  output logic             in0_a,
  input  logic             in1_v,
  input  logic [NTAG-1:0]  in1_tag,
  input  logic [NCT-1:0]   in1_ct,
  output logic             in1_a,
  output logic             out_v,
  output logic [NTAG-1:0]  out_tag,
  output logic [NCT-1:0]   out_ct,
  input  logic             out_a,
  input  logic             enable,
  input  logic [NPER-1:0]  update_period,
  output logic             update_pulse,
  output logic [NSTAT-1:0] count0,
  output logic [NSTAT-1:0] count1
);

  localparam logic [NSTAT-1:0] c_stat_one = NSTAT'(1);

  logic             r_out_v;
  logic [NTAG-1:0]  r_out_tag;
  logic [NCT-1:0]   r_out_ct;
  grant_e           r_last;
  logic [NSTAT-1:0] r_count0;
  logic [NSTAT-1:0] r_count1;

  logic w_free;
  logic w_g0;
  logic w_g1;

  assign w_free = !r_out_v || out_a;
  assign w_g0   = w_free && in0_v && (!in1_v || (r_last == GRANT1));
  assign w_g1   = w_free && in1_v && (!in0_v || (r_last == GRANT0));

  // Accepts are combinational, so they are masked while reset is held
  assign in0_a = w_g0 && reset_n;
  assign in1_a = w_g1 && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_v   <= 1'b0;
      r_out_tag <= '0;
      r_out_ct  <= '0;
      r_last    <= GRANT1;
    end else if (w_free) begin
      r_out_v <= w_g0 || w_g1;
      if (w_g0) begin
        r_out_tag <= in0_tag;
        r_out_ct  <= in0_ct;
        r_last    <= GRANT0;
      end else if (w_g1) begin
        r_out_tag <= in1_tag;
        r_out_ct  <= in1_ct;
        r_last    <= GRANT1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      if (w_g0 && (r_count0 != '1)) r_count0 <= r_count0 + c_stat_one;
      if (w_g1 && (r_count1 != '1)) r_count1 <= r_count1 + c_stat_one;
    end
  end

  assign out_v   = r_out_v;
  assign out_tag = r_out_tag;
  assign out_ct  = r_out_ct;
  assign count0  = r_count0;
  assign count1  = r_count1;

  update_timer #(
    .NPER (NPER)
  ) u_update_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .update_period (update_period),
    .update_pulse  (update_pulse)
  );

endmodule

`default_nettype wire

// File: doc/spike_filter_sched.md
SPIKE_FILTER_SCHED -- requirements
Module: spike_filter_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NTAG, 11, tag width; NCT, 10, count width; NPER, 24, update-period width; NSTAT, 16, statistic counter width.
REQ-002 Port clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports in0_v/in1_v  in  1  source valid; in0_tag/in1_tag  in  NTAG; in0_ct/in1_ct  in  NCT; in0_a/in1_a  out  1  source accept.
REQ-005 Ports out_v  out  1; out_tag  out  NTAG; out_ct  out  NCT; out_a  in  1  merged tag/count stream to the spike filter array.
REQ-006 Ports enable  in  1  update timer run; update_period  in  NPER  clks between update pulses.
REQ-007 Port update_pulse  out  1  single-cycle decay-update request to the filter array.
REQ-008 Ports count0/count1  out  NSTAT  saturating count of transfers accepted from in0/in1.

Function
REQ-009 A transfer on any channel SHALL occur in the cycle where its v and a are both high.
REQ-010 The output SHALL be one register stage (out_v, out_tag, out_ct); it SHALL be "free" when out_v is low or out_a is high.
REQ-011 inN_a SHALL be high only when the output is free, inN_v is high, and input N wins arbitration; at most one of in0_a/in1_a SHALL be high per cycle.
REQ-012 Arbitration SHALL be round-robin: a 1-bit last-grant pointer; if only one input is valid it wins; if both are valid, the input not last granted wins; the pointer updates only on an accepted input transfer.
REQ-013 An input accepted in cycle N SHALL appear on out_v/out_tag/out_ct in cycle N+1, unmodified; with out_a held high, throughput SHALL be one transfer per cycle.
REQ-014 When the output is held (out_v & ~out_a), out_tag/out_ct SHALL remain stable, and neither input is accepted.
REQ-015 When the output is free and no input is accepted, out_v SHALL go low next cycle.
REQ-016 The timer SHALL be an NPER-bit counter: with enable high and update_period nonzero it increments each cycle; when counter >= update_period-1, update_pulse is high that cycle and the counter returns to 0.
REQ-017 If update_period is reduced below the current count, the next cycle SHALL pulse and wrap (>= compare, no lost pulse).
REQ-018 enable low or update_period==0 SHALL clear the counter to 0 and hold update_pulse low; update_period==1 SHALL pulse every cycle.
REQ-019 update_pulse SHALL be registered, never last more than one cycle per period, and be independent of out_a/stall.
REQ-020 count0/count1 SHALL increment on each accepted transfer of their input and saturate at all-ones.

Reset
REQ-021 While reset_n is low: out_v=0, out_tag=0, out_ct=0, in0_a=in1_a=0, update_pulse=0, timer=0, last-grant pointer=1 (in0 wins first tie), count0=count1=0.
REQ-022 Reset asserted mid-transfer SHALL discard the output register contents; no transfer is replayed after release.
REQ-023 After reset_n rises, the first update_pulse SHALL occur update_period cycles later (enable high).

Structure
REQ-024 Shared package SHALL hold default widths (NTAG, NCT, NPER, NSTAT) and the grant-pointer enum {GRANT0, GRANT1}.
REQ-025 The timer SHALL be a separate sub-module update_timer (clk, reset_n, enable, update_period, update_pulse); arbiter, output register, and counters stay in the top.

Verification
REQ-026 in0 and in1 valid continuously (tags 3 and 7, ct 1 and 2), out_a=1 -> output alternates 3,7,3,7 starting with 3, one per cycle; count0=count1 after even cycles.
REQ-027 in1 alone, tag 5 ct 4, out_a=0 for 5 cycles then 1 -> in1_a pulses once, out_v high with tag 5 ct 4 stable for all 5 stall cycles, single transfer.
REQ-028 enable=1, update_period=64 -> update_pulse high exactly 1 cycle every 64; period 1 -> high every cycle; period 0 -> never high.
REQ-029 Counter at 50 of 64, period changed to 10 -> pulse next cycle, then every 10.
REQ-030 Random v/a on all channels, 10000 cycles, scoreboard -> output stream equals accepted inputs in order, no drops or duplicates, never both in0_a and in1_a high.
REQ-031 reset_n pulsed low while out_v=1 and out_a=0 -> all outputs zero during reset, no output transfer of the held item after release.
